// File: rtl/jtkcpu_pkg.sv
// ---------------------------------------------------------------------------
// jtkcpu_pkg
// Shared definitions for the KCPU core slice.
//   pshpul_state_t : push/pull sequencer states (IDLE, XFER, DONE)
//   PSH_CC..PSH_PC : bit positions of the push/pull postbyte
//   rev8()         : bit-reverse helper used by the set-bit picker
// ---------------------------------------------------------------------------
package jtkcpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } pshpul_state_t;

    // Postbyte bit positions. Bits PSH_X and above name 16-bit registers,
    // which take two bus cycles each.
    localparam int PSH_CC = 0;
    localparam int PSH_A  = 1;
    localparam int PSH_B  = 2;
    localparam int PSH_DP = 3;
    localparam int PSH_X  = 4;
    localparam int PSH_Y  = 5;
    localparam int PSH_SP = 6;
    localparam int PSH_PC = 7;

    // Mirror an 8-bit vector so that "highest set bit" can reuse the
    // cheaper "lowest set bit" trick.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/jtkcpu_pshpul_pick.sv
// ---------------------------------------------------------------------------
// jtkcpu_pshpul_pick
// Combinational one-hot picker for the push/pull sequencer.
//   bits    : candidate bit vector (remaining postbyte bits)
//   highest : 1 = select the highest set bit, 0 = select the lowest
//   onehot  : the selected bit, or zero when bits is zero
// ---------------------------------------------------------------------------
module jtkcpu_pshpul_pick
    import jtkcpu_pkg::*;
(
    input  logic [7:0] bits,
    input  logic       highest,
    output logic [7:0] onehot
);

    logic [7:0] scan;
    logic [7:0] lowest;

    // x & -x isolates the lowest set bit; mirroring before and after turns
    // it into a highest-set-bit search without a second priority chain.
    always_comb begin
        scan   = highest ? rev8(bits) : bits;
        lowest = scan & (~scan + 8'd1);
        onehot = highest ? rev8(lowest) : lowest;
    end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// ---------------------------------------------------------------------------
// jtkcpu_pshpul
// Push/pull (PSHS/PSHU/PULS/PULU) bus sequencer.
//   clk, rst_n, cen     : clock, async active-low reset, clock enable
//   start, pul, ussel   : begin a transfer; direction; stack select
//   mask, sp            : postbyte and starting stack pointer
//   din                 : register-file byte for the current sel/hilon
//   mem_req, mem_ack    : bus handshake, one byte per cen&&mem_ack cycle
//   addr, we, dout      : bus address, write enable, write data
//   rdata               : bus read data (consumed by the register file on ld)
//   sel, hilon, ld      : current register, high-byte flag, pull load strobe
//   busy, done          : sequencer activity, one-cycle completion pulse
//   sp_out, sp_we       : final stack pointer and its write strobe
// ---------------------------------------------------------------------------
module jtkcpu_pshpul
    import jtkcpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        start,
    input  logic        pul,
    input  logic        ussel,
    input  logic [7:0]  mask,
    input  logic [15:0] sp,
    input  logic [7:0]  din,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [15:0] addr,
    output logic        we,
    output logic [7:0]  dout,
    input  logic [7:0]  rdata,
    output logic [7:0]  sel,
    output logic        hilon,
    output logic        ld,
    output logic        busy,
    output logic        done,
    output logic [15:0] sp_out,
    output logic        sp_we
);

    pshpul_state_t state, state_next;

    logic        pul_r;
    logic        ussel_r;
    logic [7:0]  mask_r;
    logic [15:0] ptr;
    logic        phase;       // 0 = first byte of a register, 1 = second

    logic [7:0]  pick;
    logic        is16;
    logic        step;
    logic        reg_done;
    logic        last;

    // The register file decodes which pointer "other stack" means from its
    // own copy of the stack select, and it captures rdata itself on ld, so
    // neither value is consumed here.
    logic        ussel_unused;
    logic [7:0]  rdata_unused;
    assign ussel_unused = ussel_r;
    assign rdata_unused = rdata;

    // Pushes go from PC downwards (highest bit first), pulls from CC upwards.
    jtkcpu_pshpul_pick u_pick (
        .bits    (mask_r),
        .highest (~pul_r),
        .onehot  (pick)
    );

    // A byte completes on every enabled, acknowledged XFER cycle. A register
    // is finished after its single byte, or after the second byte if it is
    // 16-bit; the transfer ends when no other bits remain.
    always_comb begin
        is16     = |pick[PSH_PC:PSH_X];
        step     = (state == XFER) && cen && mem_ack;
        reg_done = !(is16 && !phase);
        last     = reg_done && ((mask_r & ~pick) == 8'd0);
    end

    // State register; everything only moves forward when cen is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_next;
        end
    end

    // Next-state and bus/handshake outputs. Outputs are zero outside the
    // states that drive them so an idle sequencer is fully quiet.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        addr       = 16'd0;
        we         = 1'b0;
        dout       = 8'd0;
        sel        = 8'd0;
        hilon      = 1'b0;
        ld         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sp_out     = 16'd0;
        sp_we      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (mask != 8'd0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                sel     = pick;
                // Push stores low then high (stack grows down, so the high
                // byte ends at the lower address); pull reads high first.
                hilon   = is16 && (phase ^ pul_r);
                addr    = pul_r ? ptr : ptr - 16'd1;
                we      = ~pul_r;
                dout    = pul_r ? 8'd0 : din;
                ld      = pul_r && mem_ack;
                if (mem_ack && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                sp_we      = 1'b1;
                sp_out     = ptr;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // ld must not fire on a frozen (cen low) cycle.
        ld = ld && cen;
    end

    // Transfer context: latched at start, then the pointer walks one byte per
    // completed bus cycle and finished bits are cleared from the mask copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pul_r   <= 1'b0;
            ussel_r <= 1'b0;
            mask_r  <= 8'd0;
            ptr     <= 16'd0;
            phase   <= 1'b0;
        end else if (cen) begin
            if (state == IDLE && start) begin
                pul_r   <= pul;
                ussel_r <= ussel;
                mask_r  <= mask;
                ptr     <= sp;
                phase   <= 1'b0;
            end else if (step) begin
                ptr <= pul_r ? ptr + 16'd1 : ptr - 16'd1;
                if (reg_done) begin
                    phase  <= 1'b0;
                    mask_r <= mask_r & ~pick;
                end else begin
                    phase  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/jtkcpu_pshpul.md
JTKCPU_PSHPUL -- requirements
Module: jtkcpu_pshpul

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port cen  input  1  clock enable; state and registers advance only when it is high.
REQ-004 SHALL have port start  input  1  begin a push/pull; sampled only in IDLE.
REQ-005 SHALL have port pul  input  1  0 = push (memory write), 1 = pull (memory read); latched at start.
REQ-006 SHALL have port ussel  input  1  0 = S stack, 1 = U stack; latched at start.
REQ-007 SHALL have port mask  input  8  postbyte: b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 other-stack pointer, b7 PC; latched at start.
REQ-008 SHALL have port sp  input  16  stack pointer value; latched at start.
REQ-009 SHALL have port din  input  8  byte to push for the current sel/hilon, from the register file.
REQ-010 SHALL have ports mem_req (output, 1), mem_ack (input, 1), addr (output, 16), we (output, 1), dout (output, 8), rdata (input, 8) for the memory bus.
REQ-011 SHALL have port sel  output  8  one-hot current register, zero when idle.
REQ-012 SHALL have port hilon  output  1  1 = high byte of a 16-bit register in transfer.
REQ-013 SHALL have port ld  output  1  one-cycle strobe: rdata valid for sel/hilon during a pull.
REQ-014 SHALL have ports busy (output, 1), done (output, 1 pulse), sp_out (output, 16), sp_we (output, 1 pulse, coincident with done).

Function
REQ-015 SHALL implement states IDLE, XFER, DONE.
REQ-016 IDLE: start with cen -> latch pul/ussel/mask/sp; next XFER if mask non-zero, else DONE.
REQ-017 Push order: PC, other-SP, Y, X (low byte then high byte each), DP, B, A, CC; highest set bit first.
REQ-018 Pull order: CC, A, B, DP, X, Y, other-SP, PC (high byte then low byte each); lowest set bit first.
REQ-019 Push byte: addr = ptr-1, we=1, dout=din; on mem_ack with cen, ptr <= ptr-1.
REQ-020 Pull byte: addr = ptr, we=0; on mem_ack with cen, ld=1 that cycle, ptr <= ptr+1.
REQ-021 mem_req SHALL stay high throughout XFER; each cen&&mem_ack cycle completes exactly one byte; a zero-wait bus gives one byte per cycle.
REQ-022 For bits 4-7, the bit clears only after the second byte; for bits 0-3, after the single byte.
REQ-023 Without mem_ack, addr/we/dout/sel/hilon SHALL hold stable.
REQ-024 XFER -> DONE when the last set bit completes; DONE lasts one cycle with done=1, sp_we=1, sp_out=final ptr; then IDLE.
REQ-025 busy SHALL be high in XFER and DONE; start is ignored while busy.
REQ-026 ptr arithmetic SHALL be 16-bit modulo, wrapping 0x0000 to 0xFFFF on push and 0xFFFF to 0x0000 on pull.
REQ-027 mask 0xFF SHALL transfer 12 bytes; cen low freezes everything, including mem_ack sampling.

Reset
REQ-028 rst_n low SHALL force IDLE and zero all outputs and internal registers (ptr, latched mask, hilon) immediately, including mid-transfer.
REQ-029 Operation SHALL begin on the first start after rst_n rises; no partial transfer resumes.

Structure
REQ-030 State encoding and mask bit constants (PSH_CC to PSH_PC) SHALL live in the shared package jtkcpu_pkg.
REQ-031 Bit selection SHALL be one sub-module, jtkcpu_pshpul_pick: a combinational highest/lowest set-bit one-hot picker with a direction input.

Verification
REQ-032 Push mask 0xFF, sp 0x1000, zero-wait -> writes 0x0FFF PC lo through 0x0FF4 CC, in 12 consecutive cycles; sp_out 0x0FF4.
REQ-033 Pull mask 0x81, sp 0x0FF4 -> reads 0x0FF4 CC, 0x0FF5 PC hi, 0x0FF6 PC lo, with 3 ld strobes; sp_out 0x0FF7.
REQ-034 Mask 0x00 start at cycle N -> done/sp_we at N+1 with sp_out = sp, no mem_req, IDLE at N+2.
REQ-035 mem_ack low for 3 cycles on the 2nd byte of push 0x10 -> addr, dout and hilon stay stable, then the transfer completes.
REQ-036 Push 0x01 with sp 0x0000 -> write at 0xFFFF, sp_out 0xFFFF; rst_n low mid-XFER -> mem_req, busy and sel go 0 asynchronously.
